// File: rtl/reg_dest_scoreboard.sv
// Destination-register scoreboard for multi-cycle writebacks (FPU, mult/div).
// Stalls issue on RAW/WAW hazards against pending writes or when the outstanding limit is hit.
module reg_dest_scoreboard #(
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs,
  input  logic [4:0]       issue_rt,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             issue_accept,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] outstanding,
  output logic             wb_err
);

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wb_err;

  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_set;
  logic             w_clr;
  logic             w_err;
  logic [31:0]      w_busy_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;

  // Bit 0 of r_busy is never set, so register 0 can never contribute a hazard.
  assign w_raw  = r_busy[issue_rs] | r_busy[issue_rt];
  assign w_waw  = issue_wr & r_busy[issue_rd];
  assign w_full = issue_wr & (issue_rd != 5'd0) & (r_cnt == CNT_W'(MAX_OUT));

  assign stall        = issue_valid & (w_raw | w_waw | w_full);
  assign issue_accept = issue_valid & ~stall;

  assign w_set = issue_accept & issue_wr & (issue_rd != 5'd0);
  assign w_clr = wb_valid & (wb_rd != 5'd0) & r_busy[wb_rd];
  assign w_err = wb_valid & (wb_rd != 5'd0) & ~r_busy[wb_rd];

  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_wb_err;
    if (flush) begin
      w_busy_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      if (w_set) w_busy_nxt[issue_rd] = 1'b1;
      if (w_clr) w_busy_nxt[wb_rd] = 1'b0;
      if (w_set && !w_clr) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (!w_set && w_clr) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      if (w_err) w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy   <= '0;
      r_cnt    <= '0;
      r_wb_err <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wb_err <= w_err_nxt;
    end
  end

  assign busy_vec    = r_busy;
  assign outstanding = r_cnt;
  assign wb_err      = r_wb_err;

  a_cnt_matches_busy: assert property (@(posedge clock) disable iff (reset)
    outstanding == CNT_W'($countones(busy_vec)));

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a pending-list model,
// a negedge monitor pops and compares them against the DUT.
module tb_reg_dest_scoreboard;

  localparam int unsigned MaxOut = 8;
  localparam int unsigned CntW   = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rs = '0;
  logic [4:0]      issue_rt = '0;
  logic [4:0]      issue_rd = '0;
  logic            issue_wr = 1'b0;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic            issue_accept;
  logic [31:0]     busy_vec;
  logic [CntW-1:0] outstanding;
  logic            wb_err;

  reg_dest_scoreboard #(
    .MAX_OUT(MaxOut),
    .CNT_W  (CntW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .issue_rd    (issue_rd),
    .issue_wr    (issue_wr),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .stall       (stall),
    .issue_accept(issue_accept),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .wb_err      (wb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        accept;
    logic [31:0] busy;
    logic [3:0]  out;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];     // registers with a pending write, in issue order
  bit   m_err;
  int   checks;
  int   errors;

  function automatic bit is_pend(input int r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall", {31'b0, stall}, {31'b0, e.stall});
      check("issue_accept", {31'b0, issue_accept}, {31'b0, e.accept});
      check("busy_vec", busy_vec, e.busy);
      check("outstanding", {28'b0, outstanding}, {28'b0, e.out});
      check("wb_err", {31'b0, wb_err}, {31'b0, e.err});
    end
  end

  // One cycle: drive inputs, record the expected view of this cycle, advance the model.
  task automatic step(input bit rst, input bit fl, input bit iv, input int rs, input int rt,
                      input int rd, input bit wr, input bit wv, input int wrd);
    exp_t e;
    bit   haz;
    @(posedge clock);
    #1;
    reset       = rst;
    flush       = fl;
    issue_valid = iv;
    issue_rs    = 5'(rs);
    issue_rt    = 5'(rt);
    issue_rd    = 5'(rd);
    issue_wr    = wr;
    wb_valid    = wv;
    wb_rd       = 5'(wrd);
    haz = is_pend(rs) || is_pend(rt) || (wr && is_pend(rd)) ||
          (wr && rd != 0 && pend.size() == MaxOut);
    e.stall  = iv && haz;
    e.accept = iv && !haz;
    e.busy   = '0;
    foreach (pend[i]) e.busy[pend[i]] = 1'b1;
    e.out    = 4'(pend.size());
    e.err    = m_err;
    exp_q.push_back(e);
    if (rst) begin
      pend.delete();
      m_err = 1'b0;
    end else if (fl) begin
      pend.delete();
    end else begin
      if (wv && wrd != 0) begin
        if (is_pend(wrd)) begin
          foreach (pend[i]) if (pend[i] == wrd) begin
            pend.delete(i);
            break;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (e.accept && wr && rd != 0) pend.push_back(rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input int rs, input int rt, input int rd, input bit wr);
    step(0, 0, 1, rs, rt, rd, wr, 0, 0);
  endtask

  task automatic wb(input int r);
    step(0, 0, 0, 0, 0, 0, 0, 1, r);
  endtask

  initial begin
    int rd_r;
    int wb_r;
    bit fl_r;
    checks = 0;
    errors = 0;
    m_err  = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // RAW on a freshly issued destination, then release by writeback
    issue(0, 0, 5, 1);
    issue(5, 0, 0, 0);
    wb(5);
    idle(1);
    issue(5, 0, 0, 0);

    // Fill to the limit, blocked ninth issue with a concurrent writeback, then retry
    for (int r = 1; r <= 8; r++) issue(0, 0, r, 1);
    step(0, 0, 1, 0, 0, 9, 1, 1, 3);
    issue(0, 0, 9, 1);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Accepted set and clear of different registers in the same cycle
    issue(0, 0, 4, 1);
    step(0, 0, 1, 0, 0, 10, 1, 1, 4);
    idle(1);

    // Spurious writeback: sticky through flush, cleared by reset
    wb(12);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Register 0 never stalls or counts; flush with three pending
    issue(0, 0, 0, 1);
    issue(0, 0, 0, 1);
    wb(0);
    issue(0, 0, 2, 1);
    issue(0, 0, 6, 1);
    issue(0, 0, 11, 1);
    step(0, 1, 1, 0, 0, 13, 1, 0, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      rd_r = $urandom_range(0, 11);
      fl_r = ($urandom_range(0, 49) == 0);
      if (pend.size() != 0 && $urandom_range(0, 9) < 7)
        wb_r = pend[$urandom_range(0, pend.size() - 1)];
      else
        wb_r = $urandom_range(0, 11);
      step(($urandom_range(0, 149) == 0), fl_r, ($urandom_range(0, 9) < 7),
           $urandom_range(0, 11), $urandom_range(0, 11), rd_r, ($urandom_range(0, 9) < 7),
           (!fl_r && $urandom_range(0, 9) < 3), wb_r);
    end

    idle(1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
